// File: rtl/wb_read_arbiter_pipe.sv
// rtl/wb_read_arbiter_pipe.sv - weight/bias SRAM read arbiter with drain-on-switch tag pipeline
module wb_read_arbiter_pipe #(
  parameter int N_LAYER = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 5,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEL_W-1:0]            weight_sel,
  input  logic [SEL_W-1:0]            bias_sel,
  input  logic [N_LAYER-1:0]          layer_read_weight_signal,
  input  logic [N_LAYER*ADDR_W-1:0]   layer_read_weight_addr,
  input  logic [N_LAYER-1:0]          layer_read_bias_signal,
  input  logic [N_LAYER*ADDR_W-1:0]   layer_read_bias_addr,
  output logic                        read_weight_signal_data,
  output logic [ADDR_W-1:0]           read_weight_addr_data,
  output logic                        read_bias_signal_data,
  output logic [ADDR_W-1:0]           read_bias_addr_data,
  input  logic [DATA_W-1:0]           weight_rdata,
  input  logic [DATA_W-1:0]           bias_rdata,
  output logic [DATA_W-1:0]           layer_weight_data,
  output logic [N_LAYER-1:0]          layer_weight_valid,
  output logic [DATA_W-1:0]           layer_bias_data,
  output logic [N_LAYER-1:0]          layer_bias_valid,
  output logic                        weight_busy,
  output logic                        bias_busy
);

  localparam int IDX_W = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_LAYER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  // Channel 0 is weight, channel 1 is bias; both run the same logic.
  logic [SEL_W-1:0]          ch_sel      [2];
  logic [N_LAYER-1:0]        ch_stb      [2];
  logic [N_LAYER*ADDR_W-1:0] ch_addr     [2];
  logic [DATA_W-1:0]         ch_rdata    [2];
  logic                      ch_en       [2];
  logic [ADDR_W-1:0]         ch_sram_addr[2];
  logic [DATA_W-1:0]         ch_data     [2];
  logic [N_LAYER-1:0]        ch_valid    [2];
  logic                      ch_busy     [2];

  assign ch_sel[0]   = weight_sel;
  assign ch_sel[1]   = bias_sel;
  assign ch_stb[0]   = layer_read_weight_signal;
  assign ch_stb[1]   = layer_read_bias_signal;
  assign ch_addr[0]  = layer_read_weight_addr;
  assign ch_addr[1]  = layer_read_bias_addr;
  assign ch_rdata[0] = weight_rdata;
  assign ch_rdata[1] = bias_rdata;

  assign read_weight_signal_data = ch_en[0];
  assign read_weight_addr_data   = ch_sram_addr[0];
  assign layer_weight_data       = ch_data[0];
  assign layer_weight_valid      = ch_valid[0];
  assign weight_busy             = ch_busy[0];
  assign read_bias_signal_data   = ch_en[1];
  assign read_bias_addr_data     = ch_sram_addr[1];
  assign layer_bias_data         = ch_data[1];
  assign layer_bias_valid        = ch_valid[1];
  assign bias_busy               = ch_busy[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   act_q, act_d;
    logic [SEL_W-1:0]   nsel;
    logic [IDX_W-1:0]   owner;
    logic [ADDR_W-1:0]  layer_addr [N_LAYER];
    logic               issue;
    logic               busy_d;
    logic               pipe_empty;
    logic [RD_LAT:0]    tag_v;
    logic [IDX_W-1:0]   tag_i [RD_LAT+1];
    logic               en_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [N_LAYER-1:0] valid_q;
    logic               busy_q;

    for (genvar l = 0; l < N_LAYER; l++) begin : g_unpack
      assign layer_addr[l] = ch_addr[ch][l*ADDR_W +: ADDR_W];
    end

    // Out-of-range selects mean "no owner".
    assign nsel       = (ch_sel[ch] != '0 && ch_sel[ch] <= SEL_MAX) ? ch_sel[ch] : '0;
    assign owner      = IDX_W'(act_q - SEL_W'(1));
    assign pipe_empty = ~|tag_v;

    // State register: committed owner and channel state.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= S_IDLE;
        act_q   <= '0;
      end else begin
        state_q <= state_d;
        act_q   <= act_d;
      end
    end

    // Next state: any select change drains outstanding reads, then commits the new owner.
    always_comb begin
      state_d = state_q;
      act_d   = act_q;
      case (state_q)
        S_IDLE, S_ACTIVE: begin
          if (nsel != act_q) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (pipe_empty) begin
            act_d   = nsel;
            state_d = (nsel == '0) ? S_IDLE : S_ACTIVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs: issue only for the committed owner while stable; busy mirrors the coming state.
    always_comb begin
      issue  = (state_q == S_ACTIVE) && (nsel == act_q) && ch_stb[ch][owner];
      busy_d = (state_d != S_ACTIVE);
    end

    // SRAM request register and busy flag (busy reads 0 while reset is held).
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_q   <= 1'b0;
        addr_q <= '0;
        busy_q <= 1'b0;
      end else begin
        en_q   <= issue;
        addr_q <= issue ? layer_addr[owner] : '0;
        busy_q <= busy_d;
      end
    end

    // Tag pipeline: last stage lines up with SRAM read data.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tag_v <= '0;
        for (int k = 0; k <= RD_LAT; k++) tag_i[k] <= '0;
      end else begin
        tag_v    <= {tag_v[RD_LAT-1:0], issue};
        tag_i[0] <= owner;
        for (int k = 1; k <= RD_LAT; k++) tag_i[k] <= tag_i[k-1];
      end
    end

    // Return path: capture data and route it by stored tag; data holds between returns.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= '0;
      end else if (tag_v[RD_LAT]) begin
        data_q  <= ch_rdata[ch];
        valid_q <= N_LAYER'(1) << tag_i[RD_LAT];
      end else begin
        valid_q <= '0;
      end
    end

    assign ch_en[ch]        = en_q;
    assign ch_sram_addr[ch] = addr_q;
    assign ch_data[ch]      = data_q;
    assign ch_valid[ch]     = valid_q;
    assign ch_busy[ch]      = busy_q;
  end

endmodule

// File: tb/tb_wb_read_arbiter_pipe.sv
// tb/tb_wb_read_arbiter_pipe.sv - self-checking bench for wb_read_arbiter_pipe
module tb_wb_read_arbiter_pipe;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [SW-1:0] wsel, bsel;
  logic [N-1:0]  wstb, bstb;
  logic [N*AW-1:0] waddr, baddr;

  // Index k = instance*2 + channel; instance 0 has RD_LAT=1, instance 1 has RD_LAT=3.
  logic          en_a    [4];
  logic [AW-1:0] addr_a  [4];
  logic [DW-1:0] data_a  [4];
  logic [DW-1:0] rd_a    [4];
  logic [N-1:0]  valid_a [4];
  logic          busy_a  [4];

  wb_read_arbiter_pipe #(.N_LAYER(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .weight_sel(wsel), .bias_sel(bsel),
    .layer_read_weight_signal(wstb), .layer_read_weight_addr(waddr),
    .layer_read_bias_signal(bstb), .layer_read_bias_addr(baddr),
    .read_weight_signal_data(en_a[0]), .read_weight_addr_data(addr_a[0]),
    .read_bias_signal_data(en_a[1]), .read_bias_addr_data(addr_a[1]),
    .weight_rdata(rd_a[0]), .bias_rdata(rd_a[1]),
    .layer_weight_data(data_a[0]), .layer_weight_valid(valid_a[0]),
    .layer_bias_data(data_a[1]), .layer_bias_valid(valid_a[1]),
    .weight_busy(busy_a[0]), .bias_busy(busy_a[1])
  );

  wb_read_arbiter_pipe #(.N_LAYER(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .weight_sel(wsel), .bias_sel(bsel),
    .layer_read_weight_signal(wstb), .layer_read_weight_addr(waddr),
    .layer_read_bias_signal(bstb), .layer_read_bias_addr(baddr),
    .read_weight_signal_data(en_a[2]), .read_weight_addr_data(addr_a[2]),
    .read_bias_signal_data(en_a[3]), .read_bias_addr_data(addr_a[3]),
    .weight_rdata(rd_a[2]), .bias_rdata(rd_a[3]),
    .layer_weight_data(data_a[2]), .layer_weight_valid(valid_a[2]),
    .layer_bias_data(data_a[3]), .layer_bias_valid(valid_a[3]),
    .weight_busy(busy_a[2]), .bias_busy(busy_a[3])
  );

  function automatic int lat_of(int k);
    return (k < 2) ? 1 : 3;
  endfunction

  // SRAM contents: a fixed function of address, different per channel.
  function automatic logic [15:0] sram_f(int c, logic [15:0] a);
    return (c == 0) ? (a ^ 16'h5A3C) : 16'(a * 3 + 16'h0101);
  endfunction

  // SRAM models: data appears RD_LAT cycles after the enable, garbage otherwise.
  logic [3:0]  en_sh [4] = '{default: '0};
  logic [15:0] ad_sh [4][4];
  logic [15:0] junk  [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      en_sh[k]    <= {en_sh[k][2:0], en_a[k]};
      ad_sh[k][0] <= addr_a[k];
      for (int j = 1; j < 4; j++) ad_sh[k][j] <= ad_sh[k][j-1];
      junk[k]     <= 16'($urandom);
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_a[k] = en_sh[k][lat_of(k)-1] ? sram_f(k % 2, ad_sh[k][lat_of(k)-1]) : junk[k];
    end
  end

  // Reference model: outstanding reads kept as a queue of {layer, return edge, data}.
  typedef struct {
    int          layer;
    int          ret;
    logic [15:0] dat;
  } item_t;

  item_t       pend [4][$];
  int          m_act [4];
  bit          m_drn [4];
  logic        e_en    [4];
  logic [15:0] e_addr  [4];
  logic [15:0] e_data  [4];
  logic [1:0]  e_valid [4];
  logic        e_busy  [4];
  int          cyc;
  int          n_chk;
  int          n_fail;

  function automatic int norm(logic [SW-1:0] s);
    return (s >= 1 && s <= N) ? int'(s) : 0;
  endfunction

  function automatic logic [SW-1:0] sel_of(int c);
    return (c == 0) ? wsel : bsel;
  endfunction

  function automatic logic stb_of(int c, int l);
    return (c == 0) ? wstb[l] : bstb[l];
  endfunction

  function automatic logic [15:0] addr_of(int c, int l);
    return (c == 0) ? waddr[l*AW +: AW] : baddr[l*AW +: AW];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      pend[k].delete();
      m_act[k]   = 0;
      m_drn[k]   = 1'b0;
      e_en[k]    = 1'b0;
      e_addr[k]  = '0;
      e_data[k]  = '0;
      e_valid[k] = '0;
      e_busy[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int    ns;
    bit    empty;
    item_t it;
    cyc++;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      int c = k % 2;
      ns    = norm(sel_of(c));
      empty = (pend[k].size() == 0);
      e_valid[k] = '0;
      if (pend[k].size() > 0 && pend[k][0].ret == cyc) begin
        e_valid[k] = 2'(1 << pend[k][0].layer);
        e_data[k]  = pend[k][0].dat;
        void'(pend[k].pop_front());
      end
      e_en[k]   = 1'b0;
      e_addr[k] = '0;
      if (m_drn[k]) begin
        if (empty) begin
          m_act[k] = ns;
          m_drn[k] = 1'b0;
        end
      end else if (ns != m_act[k]) begin
        m_drn[k] = 1'b1;
      end else if (m_act[k] != 0 && stb_of(c, m_act[k] - 1)) begin
        e_en[k]   = 1'b1;
        e_addr[k] = addr_of(c, m_act[k] - 1);
        it.layer  = m_act[k] - 1;
        it.ret    = cyc + 1 + lat_of(k);
        it.dat    = sram_f(c, e_addr[k]);
        pend[k].push_back(it);
      end
      e_busy[k] = m_drn[k] || (m_act[k] == 0);
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk("sram_en",   k, 32'(en_a[k]),    32'(e_en[k]));
      chk("sram_addr", k, 32'(addr_a[k]),  32'(e_addr[k]));
      chk("valid",     k, 32'(valid_a[k]), 32'(e_valid[k]));
      chk("data",      k, 32'(data_a[k]),  32'(e_data[k]));
      chk("busy",      k, 32'(busy_a[k]),  32'(e_busy[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic settle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [SW-1:0] pick_sel();
    case ($urandom_range(5))
      0:       return 5'd0;
      1, 3:    return 5'd1;
      2, 4:    return 5'd2;
      default: return ($urandom_range(1) == 0) ? 5'd3 : 5'd31;
    endcase
  endfunction

  typedef struct {
    logic [SW-1:0] wsel;
    logic [SW-1:0] bsel;
    logic [1:0]    wstb;
    logic [1:0]    bstb;
    logic [15:0]   a0;
    logic [15:0]   a1;
    logic          xwen;
    logic [15:0]   xwaddr;
    logic          xben;
    logic [15:0]   xbaddr;
    logic          xwbusy;
    logic          xbbusy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount, v01, v;
    bit seen;
    n_chk = 0; n_fail = 0; cyc = 0;
    model_reset();

    tbl[0] = '{5'd1,  5'd2,  2'b11, 2'b11, 16'h0100, 16'h0200, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0, 1'b0};
    tbl[1] = '{5'd2,  5'd1,  2'b01, 2'b01, 16'h0111, 16'h0222, 1'b0, 16'h0000, 1'b1, 16'h0111, 1'b0, 1'b0};
    tbl[2] = '{5'd0,  5'd0,  2'b11, 2'b11, 16'h0333, 16'h0444, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{5'd3,  5'd31, 2'b11, 2'b11, 16'h0555, 16'h0666, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{5'd1,  5'd0,  2'b10, 2'b11, 16'h0777, 16'h0888, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{5'd2,  5'd2,  2'b10, 2'b10, 16'h0999, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    tbl[6] = '{5'd8,  5'd1,  2'b11, 2'b01, 16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0};

    rst = 1'b0; wsel = '0; bsel = '0; wstb = '0; bstb = '0; waddr = '0; baddr = '0;
    settle(3);
    for (int k = 0; k < 4; k++) begin
      chk("reset_en",    k, 32'(en_a[k]),    32'd0);
      chk("reset_valid", k, 32'(valid_a[k]), 32'd0);
      chk("reset_busy",  k, 32'(busy_a[k]),  32'd0);
    end
    rst = 1'b1;

    // Owner layer0 streams three back-to-back reads.
    wsel = 5'd1;
    settle(6);
    wstb = 2'b01;
    vcount = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) waddr[15:0] = 16'h0010 + 16'(i);
      else       wstb = 2'b00;
      step();
      if (i < 3) begin
        chk("t1_en",   0, 32'(en_a[0]),   32'd1);
        chk("t1_addr", 0, 32'(addr_a[0]), 32'h0010 + 32'(i));
      end
      if (valid_a[0] != 0) begin
        chk("t1_valid", 0, 32'(valid_a[0]), 32'b01);
        chk("t1_data",  0, 32'(data_a[0]),  32'(sram_f(0, 16'h0010 + 16'(vcount))));
        chk("t1_slot",  0, i, vcount + 2);
        vcount++;
      end
    end
    chk("t1_count", 0, vcount, 3);

    // Non-owner strobe is dropped.
    wstb = 2'b10; waddr[31:16] = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_en",    0, 32'(en_a[0]),    32'd0);
      chk("t2_valid", 0, 32'(valid_a[0]), 32'd0);
      chk("t2_busy",  0, 32'(busy_a[0]),  32'd0);
    end
    wstb = 2'b00;

    // Owner switch with two reads in flight.
    wstb = 2'b01; waddr[15:0] = 16'h0040;
    step();
    waddr[15:0] = 16'h0041;
    step();
    wsel = 5'd2; wstb = 2'b10; waddr[31:16] = 16'h0030;
    v01 = 0; seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (i == 0) chk("t3_busy", 0, 32'(busy_a[0]), 32'd1);
      if (valid_a[0] == 2'b01) v01++;
      if (en_a[0]) begin
        seen = 1'b1;
        chk("t3_drained", 0, v01, 2);
        chk("t3_addr",    0, 32'(addr_a[0]), 32'h0030);
      end
    end
    if (!seen) chk("t3_issue_timeout", 0, 32'd0, 32'd1);
    wstb = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (valid_a[0] != 0) begin
        seen = 1'b1;
        chk("t3_valid", 0, 32'(valid_a[0]), 32'b10);
        chk("t3_data",  0, 32'(data_a[0]),  32'(sram_f(0, 16'h0030)));
      end
    end
    if (!seen) chk("t3_return_timeout", 0, 32'd0, 32'd1);

    // Out-of-range select: idle, nothing issues.
    wsel = 5'd7;
    settle(6);
    wstb = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_en",   0, 32'(en_a[0]),   32'd0);
      chk("t4_addr", 0, 32'(addr_a[0]), 32'd0);
      chk("t4_busy", 0, 32'(busy_a[0]), 32'd1);
    end
    wstb = 2'b00;

    // Concurrent channels with different owners.
    wsel = 5'd1; bsel = 5'd2;
    settle(6);
    wstb = 2'b01; waddr[15:0] = 16'h00A0;
    bstb = 2'b10; baddr[31:16] = 16'h00B0;
    step();
    chk("t6_wen", 0, 32'(en_a[0]), 32'd1);
    chk("t6_ben", 1, 32'(en_a[1]), 32'd1);
    chk("t6_baddr", 1, 32'(addr_a[1]), 32'h00B0);
    wstb = 2'b00; bstb = 2'b00;
    settle(2);
    chk("t6_wvalid", 0, 32'(valid_a[0]), 32'b01);
    chk("t6_wdata",  0, 32'(data_a[0]),  32'(sram_f(0, 16'h00A0)));
    chk("t6_bvalid", 1, 32'(valid_a[1]), 32'b10);
    chk("t6_bdata",  1, 32'(data_a[1]),  32'(sram_f(1, 16'h00B0)));
    settle(4);

    // Reset the cycle after an issue on the RD_LAT=3 instance.
    wstb = 2'b01; waddr[15:0] = 16'h0055;
    step();
    chk("t5_en",   2, 32'(en_a[2]),   32'd1);
    chk("t5_addr", 2, 32'(addr_a[2]), 32'h0055);
    wstb = 2'b00;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_rst_en",    k, 32'(en_a[k]),    32'd0);
      chk("t5_rst_addr",  k, 32'(addr_a[k]),  32'd0);
      chk("t5_rst_data",  k, 32'(data_a[k]),  32'd0);
      chk("t5_rst_valid", k, 32'(valid_a[k]), 32'd0);
      chk("t5_rst_busy",  k, 32'(busy_a[k]),  32'd0);
    end
    settle(2);
    rst = 1'b1;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid_a[2] != 0 || valid_a[0] != 0) v++;
    end
    chk("t5_no_stale_valid", 2, v, 0);

    // Table of single-request vectors after the select has settled.
    for (int t = 0; t < 7; t++) begin
      wsel = tbl[t].wsel; bsel = tbl[t].bsel; wstb = '0; bstb = '0;
      settle(6);
      wstb  = tbl[t].wstb; bstb = tbl[t].bstb;
      waddr = {tbl[t].a1, tbl[t].a0};
      baddr = {tbl[t].a1, tbl[t].a0};
      step();
      chk("tbl_wen",   t, 32'(en_a[0]),   32'(tbl[t].xwen));
      chk("tbl_waddr", t, 32'(addr_a[0]), 32'(tbl[t].xwaddr));
      chk("tbl_ben",   t, 32'(en_a[1]),   32'(tbl[t].xben));
      chk("tbl_baddr", t, 32'(addr_a[1]), 32'(tbl[t].xbaddr));
      chk("tbl_wbusy", t, 32'(busy_a[0]), 32'(tbl[t].xwbusy));
      chk("tbl_bbusy", t, 32'(busy_a[1]), 32'(tbl[t].xbbusy));
      wstb = '0; bstb = '0;
    end

    // Randomized traffic with occasional owner changes and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) wsel = pick_sel();
      if ($urandom_range(15) == 0) bsel = pick_sel();
      wstb  = 2'($urandom_range(3));
      bstb  = 2'($urandom_range(3));
      waddr = $urandom;
      baddr = $urandom;
      if ($urandom_range(499) == 0) begin
        rst = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
